// File: rtl/move_scheduler.sv
// Move scheduler: arbitrates keyboard and auto-play move requests, issues one
// move at a time to the game over valid/ready, then holds off for a cooldown.
module move_scheduler #(
    parameter int COOLDOWN = 25000000,
    parameter int CNT_W    = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_strobe,
    input  logic [1:0] kb_cmd,
    input  logic       auto_en,
    input  logic       auto_valid,
    input  logic [1:0] auto_cmd,
    output logic       auto_ready,
    output logic       mv_valid,
    output logic [1:0] mv_cmd,
    output logic       mv_src,
    input  logic       mv_ready,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] COOL_LOAD =
        (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

    state_t           state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       pend_cmd_q, pend_cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mv_cmd_q, mv_cmd_d;
    logic             mv_src_q, mv_src_d;
    logic [7:0]       drop_q, drop_d;

    logic kb_new;
    logic consume;

    assign kb_new     = kb_strobe && (kb_cmd != 2'd0);
    assign consume    = (state_q == S_IDLE) && pend_valid_q;
    assign auto_ready = (state_q == S_IDLE) && auto_en && !pend_valid_q;
    assign mv_valid   = (state_q == S_ISSUE);
    assign mv_cmd     = mv_cmd_q;
    assign mv_src     = mv_src_q;
    assign busy       = (state_q != S_IDLE);
    assign drop_cnt   = drop_q;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        cnt_d        = cnt_q;
        mv_cmd_d     = mv_cmd_q;
        mv_src_d     = mv_src_q;
        drop_d       = drop_q;

        // Newest key wins; a load in the same cycle as consumption is not a drop.
        if (kb_new) begin
            pend_cmd_d   = kb_cmd;
            pend_valid_d = 1'b1;
            if (pend_valid_q && !consume && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end else if (consume) begin
            pend_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_valid_q) begin
                    state_d  = S_ISSUE;
                    mv_cmd_d = pend_cmd_q;
                    mv_src_d = 1'b0;
                end else if (auto_ready && auto_valid && (auto_cmd != 2'd0)) begin
                    state_d  = S_ISSUE;
                    mv_cmd_d = auto_cmd;
                    mv_src_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (mv_ready) begin
                    if (COOLDOWN == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_COOL;
                        cnt_d   = COOL_LOAD;
                    end
                end
            end
            S_COOL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= 2'd0;
            cnt_q        <= '0;
            mv_cmd_q     <= 2'd0;
            mv_src_q     <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_cmd_q   <= pend_cmd_d;
            cnt_q        <= cnt_d;
            mv_cmd_q     <= mv_cmd_d;
            mv_src_q     <= mv_src_d;
            drop_q       <= drop_d;
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: a COOLDOWN=4 and a COOLDOWN=0 instance share inputs
// and are both tracked by a cycle-level reference model of the move rules.
module tb_move_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       kb_strobe, auto_en, auto_valid, mv_ready;
    logic [1:0] kb_cmd, auto_cmd;

    logic       ar4, v4, s4, b4, ar0, v0, s0, b0;
    logic [1:0] c4, c0;
    logic [7:0] d4, d0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    move_scheduler #(.COOLDOWN(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .kb_strobe(kb_strobe), .kb_cmd(kb_cmd),
        .auto_en(auto_en), .auto_valid(auto_valid), .auto_cmd(auto_cmd),
        .auto_ready(ar4), .mv_valid(v4), .mv_cmd(c4), .mv_src(s4),
        .mv_ready(mv_ready), .busy(b4), .drop_cnt(d4));

    move_scheduler #(.COOLDOWN(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .kb_strobe(kb_strobe), .kb_cmd(kb_cmd),
        .auto_en(auto_en), .auto_valid(auto_valid), .auto_cmd(auto_cmd),
        .auto_ready(ar0), .mv_valid(v0), .mv_cmd(c0), .mv_src(s0),
        .mv_ready(mv_ready), .busy(b0), .drop_cnt(d0));

    // Reference model: a move is either being offered, cooling down, or neither.
    typedef struct {
        bit act;
        int cmd;
        int src;
        int cool;
        bit pv;
        int pcmd;
        int drops;
    } mdl_t;

    mdl_t m4, m0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.act = 0; m.cmd = 0; m.src = 0; m.cool = 0;
        m.pv = 0; m.pcmd = 0; m.drops = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int cd);
        mdl_t n = m;
        bit idle    = !m.act && (m.cool == 0);
        bit take_kb = idle && m.pv;
        bit take_au = idle && !m.pv && auto_en && auto_valid && (auto_cmd != 0);
        if (kb_strobe && kb_cmd != 0) begin
            if (m.pv && !take_kb) n.drops = (m.drops >= 255) ? 255 : m.drops + 1;
            n.pv = 1; n.pcmd = int'(kb_cmd);
        end else if (take_kb) begin
            n.pv = 0;
        end
        if (m.act && mv_ready) begin
            n.act = 0; n.cool = cd;
        end else if (m.cool > 0) begin
            n.cool = m.cool - 1;
        end
        if (take_kb) begin
            n.act = 1; n.cmd = m.pcmd; n.src = 0;
        end else if (take_au) begin
            n.act = 1; n.cmd = int'(auto_cmd); n.src = 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Packed {mv_valid, mv_cmd, mv_src, busy, auto_ready, drop_cnt}.
    function automatic int mdl_vec(mdl_t m);
        bit idle = !m.act && (m.cool == 0);
        logic [13:0] v;
        v = {m.act, 2'(m.cmd), m.src[0], !idle, idle && auto_en && !m.pv, 8'(m.drops)};
        return int'(v);
    endfunction

    task automatic check_models();
        chk("model_cd4", int'({v4, c4, s4, b4, ar4, d4}), mdl_vec(m4));
        chk("model_cd0", int'({v0, c0, s0, b0, ar0, d0}), mdl_vec(m0));
    endtask

    task automatic drive(input logic s, input logic [1:0] c, input logic ae,
                         input logic av, input logic [1:0] ac, input logic r);
        kb_strobe = s; kb_cmd = c; auto_en = ae;
        auto_valid = av; auto_cmd = ac; mv_ready = r;
        #1;
        check_models();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        m4 = mdl_next(m4, 4);
        m0 = mdl_next(m0, 0);
        @(negedge clk);
    endtask

    task automatic step(input logic s, input logic [1:0] c, input logic ae,
                        input logic av, input logic [1:0] ac, input logic r);
        drive(s, c, ae, av, ac, r);
        finish_cycle();
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
    task automatic do_reset();
        kb_strobe = 0; kb_cmd = 0; auto_en = 0; auto_valid = 0; auto_cmd = 0; mv_ready = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_cd4", int'({v4, c4, s4, b4, ar4, d4}), 0);
        chk("rst_cd0", int'({v0, c0, s0, b0, ar0, d0}), 0);
        m4 = mdl_reset();
        m0 = mdl_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic       s;
        logic [1:0] c;
        logic       ae;
        logic       av;
        logic [1:0] ac;
        logic       r;
        logic       ev;
        logic [1:0] ec;
        logic       es;
        logic       eb;
        logic       ear;
    } vec_t;

    function automatic vec_t mk(int s, int c, int ae, int av, int ac, int r,
                                int ev, int ec, int es, int eb, int ear);
        vec_t t;
        t.s = s[0]; t.c = c[1:0]; t.ae = ae[0]; t.av = av[0]; t.ac = ac[1:0]; t.r = r[0];
        t.ev = ev[0]; t.ec = ec[1:0]; t.es = es[0]; t.eb = eb[0]; t.ear = ear[0];
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        int cnt;
        rst = 1'b0;
        kb_strobe = 0; kb_cmd = 0; auto_en = 0; auto_valid = 0; auto_cmd = 0; mv_ready = 0;
        m4 = mdl_reset();
        m0 = mdl_reset();
        #2;
        chk("init_rst_cd4", int'({v4, c4, s4, b4, ar4, d4}), 0);
        chk("init_rst_cd0", int'({v0, c0, s0, b0, ar0, d0}), 0);

        // Expected outputs are for the COOLDOWN=4 instance.
        tbl.push_back(mk(1,2,0,0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1, 1,2,0,1,0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,0,1, 0,2,0,1,0));
        tbl.push_back(mk(1,1,0,0,0,0, 0,2,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,2,0,0,0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1, 1,1,0,1,0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,1, 0,1,0,1,0));
        tbl.push_back(mk(1,3,1,1,1,1, 0,1,0,1,0));
        tbl.push_back(mk(0,0,1,1,1,1, 0,1,0,0,0));
        tbl.push_back(mk(0,0,1,1,1,1, 1,3,0,1,0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,1,1,1,1, 0,3,0,1,0));
        tbl.push_back(mk(0,0,1,1,1,1, 0,3,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,1, 1,1,1,1,0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,1,0,0,1, 0,1,1,1,0));
        tbl.push_back(mk(0,0,1,0,0,1, 0,1,1,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 0,1,1,0,0));

        @(negedge clk);
        rst = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].c, tbl[i].ae, tbl[i].av, tbl[i].ac, tbl[i].r);
            chk($sformatf("tbl%0d", i), int'({v4, c4, s4, b4, ar4}),
                int'({tbl[i].ev, tbl[i].ec, tbl[i].es, tbl[i].eb, tbl[i].ear}));
            finish_cycle();
        end

        // Two keys during cooldown: one drop, only the newest is issued.
        do_reset();
        step(1, 2, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(1, 3, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("drop_one", int'(d4), 1);
        finish_cycle();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("newest_key_issued", int'({v4, c4, s4}), int'({1'b1, 2'd3, 1'b0}));
        finish_cycle();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            cnt += int'(v4);
            finish_cycle();
        end
        chk("single_move_after_cool", cnt, 0);

        // Flood of keys while a move is stalled: counter saturates.
        for (int i = 0; i < 262; i++) step(1, 2'($urandom_range(1, 3)), 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("drop_saturate", int'(d4), 255);
        finish_cycle();
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 1);

        // Zero cooldown: held auto source yields a move every other cycle.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 1, 2, 1);
            cnt += int'(v0);
            finish_cycle();
        end
        chk("cd0_move_rate", cnt, 5);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1, 0, 1);
            chk("auto_zero_cmd", int'({ar0, v0}), int'({1'b1, 1'b0}));
            finish_cycle();
        end

        // Reset mid-ISSUE with a key buffered: nothing stale comes out afterwards.
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("pre_rst_issue", int'({v4, b4}), int'({1'b1, 1'b1}));
        do_reset();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            cnt += int'(v4) + int'(b4) + int'(v0);
            finish_cycle();
        end
        chk("no_stale_move", cnt, 0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
